pixel_dispatcher: RTL and testbench
===================================

// Module: pixel_dispatcher
// PURPOSE
// Front end of the ray-tracing pipeline. Walks a frame in raster order and issues pixel jobs (x, y)
// to 1..4 compute cores in strict round-robin: pixel i goes to core (i mod N), N = no_of_extra_cores+1.
// Its issue order matches the pixel collector's round-robin read order, so results come back in raster order.
// PARAMETERS
// X_W        11  width of x coordinate / frame_width
// Y_W        10  width of y coordinate / frame_height
// MAX_CORES  4   number of core job ports (fixed at 4)
// PORTS
// aclk               in   1    clock; all logic on posedge
// aresetn            in   1    asynchronous, active-low reset
// start              in   1    one-cycle pulse; begins a frame when idle
// frame_width        in   X_W  pixels per line; sampled on accepted start
// frame_height       in   Y_W  lines per frame; sampled on accepted start
// no_of_extra_cores  in   3    active cores minus one; sampled on accepted start
// core_ready_1..4    in   1    core k can accept a job this cycle
// job_valid_1..4     out  1    job offered to core k (one-hot or zero)
// job_x              out  X_W  x coordinate of offered job (shared bus)
// job_y              out  Y_W  y coordinate of offered job (shared bus)
// job_sof            out  1    offered job is pixel (0,0)
// job_eol            out  1    offered job has x == width-1
// busy               out  1    high from accepted start until frame_done
// frame_done         out  1    one-cycle pulse after the last job transfers
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; x=y=0; core pointer=0. Reset mid-frame abandons the frame, no frame_done.
// - FSM IDLE -> DISPATCH -> DONE -> IDLE. start while busy is ignored.
// - IDLE: on start, latch width, height, N = min(no_of_extra_cores,3)+1. Both dims nonzero -> DISPATCH;
//   either dim zero -> DONE directly (no job issued). busy rises the cycle after start.
// - DISPATCH: job_valid_k high only for k = pointer+1; job_x/job_y/flags registered. First valid appears
//   the cycle after start. valid never depends on ready; once high, valid and data stay stable until transfer.
// - Transfer = job_valid_k & core_ready_k. Other cores' ready ignored; a stalled core stalls the frame
//   (no skipping). Full throughput: one job per cycle while the addressed core holds ready.
// - On transfer: x==width-1 -> x=0, y=y+1, else x=x+1; pointer = (pointer==N-1) ? 0 : pointer+1.
//   Last transfer (x==width-1, y==height-1) -> DONE; all valids low next cycle.
// - DONE: frame_done=1 for exactly one cycle, busy=0 that same cycle, then IDLE. Pointer reset to 0
//   so the next frame starts on core 1, matching the collector.
// - Arithmetic: coordinates unsigned, no overflow beyond width-1 / height-1; total jobs = width*height.
// TESTING
// - 4x2 frame, no_of_extra_cores=1, all ready -> 8 transfers on consecutive cycles, cores 1,2,1,2,..;
//   (x,y)=(0,0)..(3,0),(0,1)..(3,1); sof only on first, eol on x=3; frame_done 1 cycle after last.
// - 3x1 frame, N=3, core_ready_2 low 3 cycles -> job (1,0) held on core 2 with stable data; no job to core 3 until it transfers.
// - frame_width=0, start -> no job_valid ever; frame_done pulses 2 cycles after start; busy high 1 cycle.
// - no_of_extra_cores=7, 5x1 frame -> clamped to 4 cores: cores 1,2,3,4,1.
// - aresetn low mid-frame at pixel 5 -> all outputs 0 immediately; no frame_done; next start begins at (0,0) on core 1.
// - start pulsed while busy -> ignored; frame completes with original dims; back-to-back frame restarts on core 1.

Source files
------------

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks a frame in raster order and hands (x, y) jobs to
// 1..4 compute cores in strict round-robin, so the collector can read results
// back in the same order.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; all job outputs low
// DISPATCH | one job offered to core ptr+1, held until that core accepts
// DONE     | frame finished; next cycle pulses frame_done and drops busy
module pixel_dispatcher #(
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int MAX_CORES = 4
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           start,
  input  logic [X_W-1:0] frame_width,
  input  logic [Y_W-1:0] frame_height,
  input  logic [2:0]     no_of_extra_cores,
  input  logic           core_ready_1,
  input  logic           core_ready_2,
  input  logic           core_ready_3,
  input  logic           core_ready_4,
  output logic           job_valid_1,
  output logic           job_valid_2,
  output logic           job_valid_3,
  output logic           job_valid_4,
  output logic [X_W-1:0] job_x,
  output logic [Y_W-1:0] job_y,
  output logic           job_sof,
  output logic           job_eol,
  output logic           busy,
  output logic           frame_done
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [X_W-1:0]       width_q, width_d;
  logic [Y_W-1:0]       height_q, height_d;
  logic [1:0]           last_core_q, last_core_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [X_W-1:0]       job_x_q, job_x_d;
  logic [Y_W-1:0]       job_y_q, job_y_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic [MAX_CORES-1:0] valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [MAX_CORES-1:0] ready_vec;
  logic                 xfer;
  logic                 last_x;
  logic                 last_y;
  logic [X_W-1:0]       next_x;
  logic [Y_W-1:0]       next_y;
  logic [1:0]           next_ptr;
  logic [1:0]           clamp_core;

  // Transfer detection and next-pixel arithmetic for the job currently offered.
  always_comb begin
    ready_vec  = {core_ready_4, core_ready_3, core_ready_2, core_ready_1};
    xfer       = |(valid_q & ready_vec);
    last_x     = (job_x_q == (width_q - X_W'(1)));
    last_y     = (job_y_q == (height_q - Y_W'(1)));
    next_x     = last_x ? '0 : job_x_q + X_W'(1);
    next_y     = last_x ? job_y_q + Y_W'(1) : job_y_q;
    next_ptr   = (ptr_q == last_core_q) ? 2'd0 : ptr_q + 2'd1;
    // More than four cores requested collapses onto the four that exist.
    clamp_core = (no_of_extra_cores > 3'd3) ? 2'd3 : no_of_extra_cores[1:0];
  end

  // Frame sequencing; all job outputs are computed here and registered.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    last_core_d = last_core_q;
    ptr_d       = ptr_q;
    job_x_d     = job_x_q;
    job_y_d     = job_y_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d     = frame_width;
          height_d    = frame_height;
          last_core_d = clamp_core;
          ptr_d       = 2'd0;
          busy_d      = 1'b1;
          if ((frame_width != '0) && (frame_height != '0)) begin
            state_d = S_DISPATCH;
            job_x_d = '0;
            job_y_d = '0;
            sof_d   = 1'b1;
            eol_d   = (frame_width == X_W'(1));
            valid_d = MAX_CORES'(1);
          end else begin
            // Empty frame: no jobs, but still report completion.
            state_d = S_DONE;
          end
        end
      end
      S_DISPATCH: begin
        if (xfer) begin
          if (last_x && last_y) begin
            state_d = S_DONE;
            valid_d = '0;
            job_x_d = '0;
            job_y_d = '0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
          end else begin
            job_x_d = next_x;
            job_y_d = next_y;
            sof_d   = 1'b0;
            eol_d   = (next_x == (width_q - X_W'(1)));
            ptr_d   = next_ptr;
            valid_d = MAX_CORES'(1) << next_ptr;
          end
        end
      end
      S_DONE: begin
        // Next frame must begin on core 1 to stay aligned with the collector.
        state_d = S_IDLE;
        ptr_d   = 2'd0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      last_core_q <= 2'd0;
      ptr_q       <= 2'd0;
      job_x_q     <= '0;
      job_y_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      last_core_q <= last_core_d;
      ptr_q       <= ptr_d;
      job_x_q     <= job_x_d;
      job_y_q     <= job_y_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign job_valid_1 = valid_q[0];
  assign job_valid_2 = valid_q[1];
  assign job_valid_3 = valid_q[2];
  assign job_valid_4 = valid_q[3];
  assign job_x       = job_x_q;
  assign job_y       = job_y_q;
  assign job_sof     = sof_q;
  assign job_eol     = eol_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher: expected jobs are generated from the
// raster/round-robin rules and consumed by a monitor on each observed transfer.
module tb_pixel_dispatcher;
  localparam int X_W = 11;
  localparam int Y_W = 10;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           start;
  logic [X_W-1:0] frame_width;
  logic [Y_W-1:0] frame_height;
  logic [2:0]     no_of_extra_cores;
  logic [3:0]     rdy;
  logic           job_valid_1, job_valid_2, job_valid_3, job_valid_4;
  logic [X_W-1:0] job_x;
  logic [Y_W-1:0] job_y;
  logic           job_sof, job_eol, busy, frame_done;
  wire  [3:0]     vld = {job_valid_4, job_valid_3, job_valid_2, job_valid_1};

  pixel_dispatcher #(.X_W(X_W), .Y_W(Y_W), .MAX_CORES(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .frame_width(frame_width), .frame_height(frame_height),
    .no_of_extra_cores(no_of_extra_cores),
    .core_ready_1(rdy[0]), .core_ready_2(rdy[1]),
    .core_ready_3(rdy[2]), .core_ready_4(rdy[3]),
    .job_valid_1(job_valid_1), .job_valid_2(job_valid_2),
    .job_valid_3(job_valid_3), .job_valid_4(job_valid_4),
    .job_x(job_x), .job_y(job_y), .job_sof(job_sof), .job_eol(job_eol),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int x;
    int y;
    int core;
    bit sof;
    bit eol;
  } job_t;

  job_t exp_arr [8192];
  int   wr_ptr, rd_ptr;
  int   done_pushed, done_seen;
  int   n_tests, n_fail;
  int   cyc;
  int   hold2_end;
  bit   rand_rdy;
  int   xfer_cyc [$];

  bit             prev_stall;
  logic [3:0]     prev_vld;
  logic [X_W-1:0] prev_x;
  logic [Y_W-1:0] prev_y;
  logic           prev_sof, prev_eol;

  // Reference model: pixel i of a w x h frame is (i mod w, i / w) on core (i mod N)+1.
  task automatic push_frame(input int w, input int h, input int extra);
    int n;
    n = ((extra > 3) ? 3 : extra) + 1;
    for (int i = 0; i < w * h; i++) begin
      exp_arr[wr_ptr % 8192].x    = i % w;
      exp_arr[wr_ptr % 8192].y    = i / w;
      exp_arr[wr_ptr % 8192].core = (i % n) + 1;
      exp_arr[wr_ptr % 8192].sof  = (i == 0);
      exp_arr[wr_ptr % 8192].eol  = ((i % w) == w - 1);
      wr_ptr++;
    end
    done_pushed++;
  endtask

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic pulse_start(input int w, input int h, input int e);
    frame_width       = X_W'(w);
    frame_height      = Y_W'(h);
    no_of_extra_cores = 3'(e);
    start             = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (i < 2000 && !(rd_ptr == wr_ptr && done_seen == done_pushed)) begin
      step();
      i++;
    end
    n_tests++;
    if (rd_ptr != wr_ptr || done_seen != done_pushed) begin
      n_fail++;
      $display("FAIL %s timeout: jobs left %0d, frame_done seen %0d required %0d",
               name, wr_ptr - rd_ptr, done_seen, done_pushed);
      rd_ptr    = wr_ptr;
      done_seen = done_pushed;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_done: got %b required 0", name, busy);
    end
  endtask

  task automatic monitor_sample();
    bit   xfer;
    int   core;
    job_t e;
    if (!aresetn) begin
      prev_stall = 1'b0;
      return;
    end
    xfer = |(vld & rdy);
    if (prev_stall) begin
      n_tests++;
      if (vld !== prev_vld || job_x !== prev_x || job_y !== prev_y ||
          job_sof !== prev_sof || job_eol !== prev_eol) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b (%0d,%0d) required v=%b (%0d,%0d)",
                 vld, job_x, job_y, prev_vld, prev_x, prev_y);
      end
    end
    if (vld != 4'b0) begin
      n_tests++;
      if ($countones(vld) != 1) begin
        n_fail++;
        $display("FAIL onehot: got valids %b required a single bit", vld);
      end
    end
    if (xfer) begin
      core = 0;
      for (int k = 0; k < 4; k++) if (vld[k]) core = k + 1;
      xfer_cyc.push_back(cyc);
      n_tests++;
      if (rd_ptr == wr_ptr) begin
        n_fail++;
        $display("FAIL unexpected_job: got core %0d (%0d,%0d) required none", core, job_x, job_y);
      end else begin
        e = exp_arr[rd_ptr % 8192];
        rd_ptr++;
        if (core != e.core || int'(job_x) != e.x || int'(job_y) != e.y ||
            job_sof !== e.sof || job_eol !== e.eol) begin
          n_fail++;
          $display("FAIL job: got core %0d (%0d,%0d) sof %b eol %b required core %0d (%0d,%0d) sof %b eol %b",
                   core, job_x, job_y, job_sof, job_eol, e.core, e.x, e.y, e.sof, e.eol);
        end
      end
    end
    prev_stall = (vld != 4'b0) && !xfer;
    prev_vld   = vld;
    prev_x     = job_x;
    prev_y     = job_y;
    prev_sof   = job_sof;
    prev_eol   = job_eol;
    if (frame_done) begin
      n_tests++;
      if (done_seen >= done_pushed || rd_ptr != wr_ptr) begin
        n_fail++;
        $display("FAIL frame_done: got pulse with %0d jobs pending, done seen %0d required %0d",
                 wr_ptr - rd_ptr, done_seen, done_pushed);
      end
      done_seen++;
    end
  endtask

  initial begin
    int base, c0, w, h, e;
    logic [2:0] zseq [4];
    aresetn = 1'b0;
    start = 1'b0;
    frame_width = '0;
    frame_height = '0;
    no_of_extra_cores = '0;
    rdy = 4'hF;
    wr_ptr = 0; rd_ptr = 0; done_pushed = 0; done_seen = 0;
    n_tests = 0; n_fail = 0; cyc = 0; hold2_end = 0; rand_rdy = 1'b0;
    prev_stall = 1'b0;

    fork
      forever begin
        @(posedge aclk);
        cyc++;
        #1;
        for (int k = 0; k < 4; k++) rdy[k] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cyc < hold2_end) rdy[1] = 1'b0;
      end
      forever begin
        @(negedge aclk);
        monitor_sample();
      end
    join_none

    // Reset state
    repeat (3) step();
    n_tests++;
    if ({vld, job_x, job_y, job_sof, job_eol, busy, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b x=%0d y=%0d busy=%b done=%b required all 0",
               vld, job_x, job_y, busy, frame_done);
    end
    aresetn = 1'b1;
    repeat (2) step();

    // 4x2 frame on two cores, everything ready: one job per cycle
    xfer_cyc.delete();
    push_frame(4, 2, 1);
    pulse_start(4, 2, 1);
    c0 = cyc;
    wait_idle("frame_4x2");
    n_tests++;
    if (xfer_cyc.size() != 8 || xfer_cyc[0] != c0 || xfer_cyc[7] - xfer_cyc[0] != 7) begin
      n_fail++;
      $display("FAIL throughput_4x2: got %0d transfers, first at +%0d, span %0d required 8, +0, 7",
               xfer_cyc.size(), (xfer_cyc.size() > 0) ? xfer_cyc[0] - c0 : -1,
               (xfer_cyc.size() > 7) ? xfer_cyc[7] - xfer_cyc[0] : -1);
    end
    step();

    // 3x1 frame on three cores with core 2 stalled
    xfer_cyc.delete();
    hold2_end = cyc + 4;
    push_frame(3, 1, 2);
    pulse_start(3, 1, 2);
    wait_idle("stall_core2");
    n_tests++;
    if (xfer_cyc.size() != 3 || xfer_cyc[1] - xfer_cyc[0] != 3 || xfer_cyc[2] - xfer_cyc[1] != 1) begin
      n_fail++;
      $display("FAIL stall_timing: got %0d transfers gaps %0d,%0d required 3 transfers gaps 3,1",
               xfer_cyc.size(), (xfer_cyc.size() > 1) ? xfer_cyc[1] - xfer_cyc[0] : -1,
               (xfer_cyc.size() > 2) ? xfer_cyc[2] - xfer_cyc[1] : -1);
    end
    step();

    // Zero-width frame: busy for one cycle, frame_done two cycles after start
    zseq[0] = 3'b100; zseq[1] = 3'b010; zseq[2] = 3'b000; zseq[3] = 3'b000;
    done_pushed++;
    pulse_start(0, 5, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      #1;
      n_tests++;
      if ({busy, frame_done, |vld} !== zseq[i]) begin
        n_fail++;
        $display("FAIL zero_width cycle %0d: got busy=%b done=%b anyvalid=%b required busy=%b done=%b anyvalid=0",
                 i + 1, busy, frame_done, |vld, zseq[i][2], zseq[i][1]);
      end
    end
    wait_idle("zero_width");

    // Core count clamp: 7 extra cores behaves as 4
    push_frame(5, 1, 7);
    pulse_start(5, 1, 7);
    wait_idle("clamp_5x1");
    step();

    // Reset in the middle of a frame
    base = rd_ptr;
    push_frame(4, 3, 3);
    pulse_start(4, 3, 3);
    for (int i = 0; i < 200 && rd_ptr - base < 5; i++) step();
    aresetn = 1'b0;
    #1;
    n_tests++;
    if ({vld, job_x, job_y, job_sof, job_eol, busy, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got v=%b x=%0d y=%0d busy=%b done=%b after %0d jobs required all 0",
               vld, job_x, job_y, busy, frame_done, rd_ptr - base);
    end
    wr_ptr = rd_ptr;
    done_pushed = done_seen;
    repeat (2) step();
    aresetn = 1'b1;
    repeat (4) step();
    push_frame(3, 2, 1);
    pulse_start(3, 2, 1);
    wait_idle("after_reset");
    step();

    // start while busy is ignored; then a back-to-back frame from core 1
    push_frame(4, 2, 2);
    pulse_start(4, 2, 2);
    step();
    pulse_start(7, 3, 0);
    wait_idle("start_while_busy");
    push_frame(2, 2, 1);
    pulse_start(2, 2, 1);
    wait_idle("back_to_back");
    step();

    // Randomized frames with random readiness
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      e = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) w = 0;
      if ($urandom_range(0, 9) == 0) h = 0;
      push_frame(w, h, e);
      pulse_start(w, h, e);
      wait_idle("random_frame");
      repeat ($urandom_range(0, 2)) step();
    end
    rand_rdy = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
